// File: rtl/regfile_dump_pkg.sv
// regfile_dump_pkg: shared state encoding and default sizes for the regfile dump controller.
package regfile_dump_pkg;
  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_AW    = 5;
  localparam logic [DEF_AW-1:0] LAST_IDX = DEF_AW'(DEF_NREGS - 1);
  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND_A,
    SEND_B
`ifdef REGFILE_DUMP_LOAD_EN
    ,
    LOAD
`endif
  } state_t;
endpackage

// File: rtl/regfile_dump_loader.sv
// regfile_dump_loader: accepts load beats and registers them onto the regfile write port, x1 upward.
// Used only when REGFILE_DUMP_LOAD_EN is defined.
module regfile_dump_loader #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
)(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_active,
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_data,
  output logic            o_ready,
  output logic            o_we,
  output logic [AW-1:0]   o_rd,
  output logic [XLEN-1:0] o_wd,
  output logic            o_done
);
  logic [AW-1:0] r_idx;
  logic r_fin;
  logic r_we;
  logic [AW-1:0] r_rd;
  logic [XLEN-1:0] r_wd;
  logic w_hs;
  assign o_ready = i_active && !r_fin;
  assign w_hs = o_ready && i_valid;
  // r_fin marks the write cycle of the last register; intake stops until the controller leaves LOAD
  always_ff @(posedge clk) begin
    if (reset || !i_active) begin
      r_idx <= AW'(1);
      r_fin <= 1'b0;
      r_we  <= 1'b0;
      r_rd  <= '0;
      r_wd  <= '0;
    end else begin
      r_idx <= w_hs ? r_idx + 1'b1 : r_idx;
      r_fin <= r_fin || (w_hs && r_idx == AW'(NREGS - 1));
      r_we  <= w_hs;
      r_rd  <= w_hs ? r_idx : '0;
      r_wd  <= w_hs ? i_data : '0;
    end
  end
  assign o_we = r_we;
  assign o_rd = r_rd;
  assign o_wd = r_wd;
  assign o_done = r_fin;
endmodule

// File: rtl/regfile_dump.sv
// regfile_dump: stalls the core and streams x0..x31 out in pairs through the regfile read ports.
// Define REGFILE_DUMP_LOAD_EN to add a load mode that fills x1..x31 from the input stream.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = DEF_AW
)(
  input  logic            clk,
  input  logic            reset,
  input  logic            dump_start,
  input  logic            load_start,
  output logic            busy,
  output logic [AW-1:0]   rs1,
  output logic [AW-1:0]   rs2,
  input  logic [XLEN-1:0] rdout1,
  input  logic [XLEN-1:0] rdout2,
  output logic [AW-1:0]   rd,
  output logic [XLEN-1:0] wrs3,
  output logic            we,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [AW-1:0]   out_idx,
  output logic            out_last,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_data
);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
  state_t r_state, w_next;
  logic [AW-2:0] r_p;
  logic [XLEN-1:0] r_hold_a, r_hold_b;
  logic [AW-1:0] w_ia, w_ib;
  logic w_hs, w_last;
  assign w_ia = {r_p, 1'b0};
  assign w_ib = {r_p, 1'b1};
  assign w_hs = out_valid && out_ready;
  assign w_last = w_ib == LAST;
`ifdef REGFILE_DUMP_LOAD_EN
  logic w_load_done;
  regfile_dump_loader #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_loader (
    .clk      (clk),
    .reset    (reset),
    .i_active (r_state == LOAD),
    .i_valid  (in_valid),
    .i_data   (in_data),
    .o_ready  (in_ready),
    .o_we     (we),
    .o_rd     (rd),
    .o_wd     (wrs3),
    .o_done   (w_load_done)
  );
`else
  logic w_unused;
  assign w_unused = ^{load_start, in_valid, in_data};
  assign in_ready = 1'b0;
  assign we = 1'b0;
  assign rd = '0;
  assign wrs3 = '0;
`endif
  always_ff @(posedge clk) begin
    r_state <= reset ? IDLE : w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (dump_start) w_next = READ;
`ifdef REGFILE_DUMP_LOAD_EN
              else if (load_start) w_next = LOAD;
      LOAD:   if (w_load_done) w_next = IDLE;
`endif
      READ:   w_next = SEND_A;
      SEND_A: if (w_hs) w_next = SEND_B;
      SEND_B: if (w_hs) w_next = w_last ? IDLE : READ;
      default: w_next = IDLE;
    endcase
  end
  // pair index and captured read data; both read ports are sampled together in READ
  always_ff @(posedge clk) begin
    if (reset) begin
      r_p      <= '0;
      r_hold_a <= '0;
      r_hold_b <= '0;
    end else begin
      if (r_state == IDLE && dump_start) r_p <= '0;
      if (r_state == READ) begin
        r_hold_a <= rdout1;
        r_hold_b <= rdout2;
      end
      if (r_state == SEND_B && w_hs && !w_last) r_p <= r_p + 1'b1;
    end
  end
  always_comb begin
    busy      = r_state != IDLE;
    rs1       = r_state == READ ? w_ia : '0;
    rs2       = r_state == READ ? w_ib : '0;
    out_valid = r_state == SEND_A || r_state == SEND_B;
    out_data  = r_state == SEND_A ? r_hold_a : r_state == SEND_B ? r_hold_b : '0;
    out_idx   = r_state == SEND_A ? w_ia : r_state == SEND_B ? w_ib : '0;
    out_last  = r_state == SEND_B && w_last;
  end
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: bench for regfile_dump with a regfile model, a stream-level reference model and directed vectors.
// Exercises the load path when REGFILE_DUMP_LOAD_EN is defined.
module tb_regfile_dump;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dump_start = 1'b0;
  logic load_start = 1'b0;
  logic out_ready = 1'b1;
  logic in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic busy, we, out_valid, out_last, in_ready;
  logic [4:0] rs1, rs2, rd, out_idx;
  logic [31:0] rdout1, rdout2, wrs3, out_data;
  logic [31:0] rf [32] = '{default: '0};
  logic core_we = 1'b0;
  logic [4:0] core_rd = '0;
  logic [31:0] core_wd = '0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit m_busy = 0, m_dump = 0, m_gap = 0, m_load = 0, m_lfin = 0, m_we = 0;
  int m_idx = 0, m_lidx = 0, m_rd = 0, beats = 0;
  logic [31:0] m_wd = '0;
  logic [31:0] m_rf [32] = '{default: '0};

  regfile_dump dut (
    .clk(clk), .reset(reset), .dump_start(dump_start), .load_start(load_start), .busy(busy),
    .rs1(rs1), .rs2(rs2), .rdout1(rdout1), .rdout2(rdout2), .rd(rd), .wrs3(wrs3), .we(we),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // environment regfile: x0 reads as zero, DUT write port has priority over the core path
  assign rdout1 = rs1 == 5'd0 ? '0 : rf[rs1];
  assign rdout2 = rs2 == 5'd0 ? '0 : rf[rs2];
  always @(posedge clk) begin
    if (we && rd != 5'd0) rf[rd] <= wrs3;
    else if (core_we) rf[core_rd] <= core_wd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_rs1"}, 32'(rs1), 0);
    chk({tag, "_rs2"}, 32'(rs2), 0);
    chk({tag, "_rd"}, 32'(rd), 0);
    chk({tag, "_wrs3"}, wrs3, 0);
    chk({tag, "_we"}, 32'(we), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_idx"}, 32'(out_idx), 0);
    chk({tag, "_out_last"}, 32'(out_last), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
  endtask

  // reference model: one beat per index in order, a read cycle before each even index
  task automatic step();
    bit ev;
    ev = m_dump && !m_gap;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("out_valid", 32'(out_valid), 32'(ev));
    if (ev) begin
      chk("out_idx", 32'(out_idx), 32'(m_idx));
      chk("out_data", out_data, m_rf[m_idx]);
      chk("out_last", 32'(out_last), 32'(m_idx == 31));
    end
    chk("rs1", 32'(rs1), (m_dump && m_gap) ? 32'(m_idx) : 0);
    chk("rs2", 32'(rs2), (m_dump && m_gap) ? 32'(m_idx + 1) : 0);
    chk("in_ready", 32'(in_ready), 32'(m_load && !m_lfin));
    chk("we", 32'(we), 32'(m_we));
    if (m_we) begin
      chk("rd", 32'(rd), 32'(m_rd));
      chk("wrs3", wrs3, m_wd);
    end
    m_we = 0;
    if (reset) begin
      {m_busy, m_dump, m_gap, m_load, m_lfin} = '0;
      m_idx = 0;
    end else if (!m_busy) begin
      if (dump_start) begin
        {m_busy, m_dump, m_gap} = 3'b111;
        m_idx = 0;
      end
`ifdef REGFILE_DUMP_LOAD_EN
      else if (load_start) begin
        {m_busy, m_load, m_lfin} = 3'b110;
        m_lidx = 1;
      end
`endif
    end else if (m_dump) begin
      if (m_gap) m_gap = 0;
      else if (out_ready) begin
        beats++;
        if (m_idx == 31) {m_busy, m_dump} = 2'b00;
        else begin
          m_gap = (m_idx % 2) == 1;
          m_idx++;
        end
      end
    end else if (m_load) begin
      if (m_lfin) {m_busy, m_load, m_lfin} = 3'b000;
      else if (in_valid) begin
        m_rf[m_lidx] = in_data;
        m_we = 1;
        m_rd = m_lidx;
        m_wd = in_data;
        if (m_lidx == 31) m_lfin = 1;
        m_lidx++;
      end
    end
  endtask

  initial begin
    int t0, fv, b0, st, nwe, k;
    bit p10, p12, hs;
    logic [31:0] d1, d31;
    fv = -1;
    d1 = '0;
    d31 = '0;
    tick();
    chk_zero("reset");
    fork
      forever begin
        @(negedge clk);
        step();
      end
    join_none
    reset = 1'b0;
    for (int i = 1; i < 32; i++) begin
      core_we = 1'b1;
      core_rd = 5'(i);
      core_wd = 32'(32'h100 + i);
      m_rf[i] = 32'(32'h100 + i);
      tick();
    end
    core_we = 1'b0;
    tick();
    // full dump, sink always ready
    dump_start = 1'b1;
    t0 = cyc;
    b0 = beats;
    tick();
    dump_start = 1'b0;
    chk("busy_cycle1", 32'(busy), 1);
    for (int n = 0; n < 200 && busy; n++) begin
      if (out_valid && fv < 0) fv = cyc - t0;
      tick();
    end
    chk("first_valid_cycle", 32'(fv), 2);
    chk("busy_drop_cycle", 32'(cyc - t0), 49);
    chk("beats_dump1", 32'(beats - b0), 32);
    tick();
    // backpressure at idx 7, ignored start pulses at idx 10 and 12
    dump_start = 1'b1;
    b0 = beats;
    st = 0;
    p10 = 0;
    p12 = 0;
    tick();
    dump_start = 1'b0;
    for (int n = 0; n < 300 && busy; n++) begin
      out_ready = 1'b1;
      dump_start = 1'b0;
      load_start = 1'b0;
      if (out_valid && out_idx == 5'd7 && st < 5) begin
        chk("stall_data", out_data, 32'h107);
        chk("stall_idx", 32'(out_idx), 7);
        out_ready = 1'b0;
        st++;
      end
      if (out_valid && out_idx == 5'd10 && !p10) begin
        dump_start = 1'b1;
        p10 = 1;
      end
      if (out_valid && out_idx == 5'd12 && !p12) begin
        load_start = 1'b1;
        p12 = 1;
      end
      tick();
    end
    out_ready = 1'b1;
    dump_start = 1'b0;
    load_start = 1'b0;
    chk("busy_end_dump2", 32'(busy), 0);
    chk("beats_dump2", 32'(beats - b0), 32);
    chk("stall_cycles", 32'(st), 5);
    tick();
    // reset in the middle of a dump, then restart from x0
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int n = 0; n < 100 && !(out_valid && out_idx == 5'd12); n++) tick();
    chk("reached_idx12", 32'(out_idx), 12);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_zero("after_reset");
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int n = 0; n < 10 && !out_valid; n++) tick();
    chk("restart_valid", 32'(out_valid), 1);
    chk("restart_idx", 32'(out_idx), 0);
    chk("restart_data", out_data, 0);
    for (int n = 0; n < 200 && busy; n++) tick();
    chk("busy_end_dump3", 32'(busy), 0);
    tick();
`ifdef REGFILE_DUMP_LOAD_EN
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("load_busy", 32'(busy), 1);
    k = 1;
    nwe = 0;
    in_valid = 1'b1;
    in_data = 32'hA1;
    for (int n = 0; n < 200; n++) begin
      hs = in_valid && in_ready;
      tick();
      if (we) nwe++;
      if (hs) begin
        k++;
        if (k > 31) in_valid = 1'b0;
        else in_data = 32'(32'hA0 + k);
      end
      if (!busy) break;
    end
    in_valid = 1'b0;
    chk("we_pulses", 32'(nwe), 31);
    chk("load_done_busy", 32'(busy), 0);
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int n = 0; n < 100 && busy; n++) begin
      if (out_valid && out_idx == 5'd1) d1 = out_data;
      if (out_valid && out_idx == 5'd31) d31 = out_data;
      tick();
    end
    chk("loaded_x1", d1, 32'hA1);
    chk("loaded_x31", d31, 32'hBF);
`else
    in_valid = 1'b1;
    in_data = 32'h55;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int n = 0; n < 4; n++) begin
      chk("noload_in_ready", 32'(in_ready), 0);
      chk("noload_we", 32'(we), 0);
      chk("noload_busy", 32'(busy), 0);
      tick();
    end
    in_valid = 1'b0;
`endif
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
